mem_stage_mc: RTL
=================

# mem_stage_mc

Parametrised, multi-cycle successor of the pipeline MEM stage. It sits between the EXE/MEM and MEM/WB pipeline registers and owns the data memory. Depth, base address and access latency are set by parameters, and it supports word and byte accesses. It detects out-of-range and misaligned addresses, and stalls the pipeline through `ready` while an access is in flight.

## Interface
- `DATA_W`, 32: data and address width; fixed at 32 for byte-lane logic.
- `DEPTH`, 64: number of DATA_W words in data memory; power of two.
- `BASE_ADDR`, 1024: byte address of word 0.
- `LATENCY`, 0: wait cycles per access; 0 gives single-cycle behaviour.
- `REG_W`, 4: destination register index width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `MEM_R_EN_in`  in  1  load request.
- `MEM_W_EN_in`  in  1  store request.
- `WB_Enable_in`  in  1  writeback enable from EXE.
- `byte_mode`  in  1  1 = byte access (LDRB/STRB), 0 = word.
- `Reg_Dest_in`  in  REG_W  destination register.
- `Val_RM`  in  DATA_W  store data.
- `ALU_result_in`  in  DATA_W  byte address.
- `ready`  out  1  0 = stall the pipeline; upstream holds all inputs stable.
- `MEM_R_EN_out`  out  1  load flag to WB.
- `WB_Enable_out`  out  1  writeback enable to WB.
- `Reg_Dest`  out  REG_W  pass-through.
- `ALU_result`  out  DATA_W  pass-through.
- `mem_read_data`  out  DATA_W  load data.
- `addr_err`  out  1  address fault on the current request.

## Operation
- Request: `req = MEM_R_EN_in | MEM_W_EN_in`.
- Address fault (`addr_err` = 1) when `addr < BASE_ADDR`, or `addr >= BASE_ADDR + 4*DEPTH`, or when `byte_mode` = 0 and `addr[1:0]` ≠ 0.
  - On a fault: no memory access, no stall, `mem_read_data` = 0, `WB_Enable_out` = 0.
- Address arithmetic: `off = addr - BASE_ADDR`, computed modulo 2^32.
  - Word index = `off[log2(DEPTH)+1:2]`.
  - Byte lane = `off[1:0]`.
- Byte store writes only the addressed lane, using `Val_RM[7:0]`.
- Byte load returns the lane zero-extended to 32 bits.
- Pass-throughs are combinational: `Reg_Dest`, `ALU_result`, `MEM_R_EN_out`, and `WB_Enable_out` (the last is gated only by `addr_err`).
- FSM states are IDLE and BUSY; `wcnt` is a counter of width `clog2(LATENCY+1)`.
  - In IDLE with no request, or with a faulted request: `ready` = 1.
  - In IDLE with a valid request and `LATENCY` = 0: the access completes this cycle, `ready` = 1, and the store commits at this edge.
  - In IDLE with a valid request and `LATENCY` > 0: `ready` = 0, go to BUSY, `wcnt` ← 1.
  - In BUSY with `wcnt` < `LATENCY`: `ready` = 0, `wcnt` increments.
  - In BUSY with `wcnt` = `LATENCY` (completion cycle): `ready` = 1, the store commits at this edge, go to IDLE.
- `mem_read_data` carries the memory word only in the completion cycle of a load; otherwise it is 0 (never Z).
- If `req` drops while in BUSY (upstream protocol violation), go to IDLE with no write.

## Timing
- Reset (`rst` = 0 at a clock edge):
  - State → IDLE, `wcnt` → 0.
  - Memory contents are not cleared.
  - While `rst` = 0: `ready` = 1, `WB_Enable_out` = 0, `MEM_R_EN_out` = 0, `mem_read_data` = 0, `addr_err` = 0, and no write occurs.
- Reset in mid-access aborts the access; a pending store is never committed.
- Total access latency is `LATENCY` + 1 cycles, counted from the request cycle to the completion cycle inclusive. `ready` is low for exactly `LATENCY` cycles.
- Back-to-back requests: a new request can be accepted in the cycle immediately after a completion, because the FSM is in IDLE.
- Reads are asynchronous from the array; writes are synchronous; `ready` and `addr_err` are combinational from state and inputs.

## Structure
- Package `mem_stage_pkg` holds:
  - the state enum `mem_state_t` (IDLE, BUSY);
  - lane-enable function `byte_we(lane, byte_mode)` returning 4 bits;
  - a zero-extend helper.
- Sub-module `data_ram`: DEPTH × 32 array with 4-bit byte write-enable, synchronous write, asynchronous read. The parent contains the FSM, fault check and output muxing.

## Test plan
- `LATENCY` = 0, store word 0xDEADBEEF at 1024, then load at 1024 → `ready` stays 1 throughout, load returns 0xDEADBEEF in the same cycle, `WB_Enable_out` = 1.
- `LATENCY` = 3, load at 1028 → `ready` = 0 for 3 cycles, then 1 on the 4th cycle with `mem_read_data` = stored word; `mem_read_data` = 0 in the stall cycles.
- Byte mode: store 0xAB at 1025 over existing word 0x11223344 → word becomes 0x1122AB44; byte load at 1025 returns 0x000000AB.
- Faults: word load at 1026, load at 1020, store at 1024+4*DEPTH → `addr_err` = 1, `ready` = 1, no write (memory readback unchanged), `WB_Enable_out` = 0.
- `LATENCY` = 3, store issued, `rst` = 0 in BUSY cycle 2 → after release: state IDLE, `ready` = 1, target word unchanged.
- Back-to-back: store at 1032 completes, then a load at 1032 in the next cycle → returns the new value after `LATENCY` stall cycles.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state type and byte-lane helpers for the MEM stage
package mem_stage_pkg;

   typedef enum logic {IDLE, BUSY} mem_state_t;

   function automatic logic [3:0] byte_we(input logic [1:0] lane, input logic byte_mode);
      return byte_mode ? 4'b0001 << lane : 4'b1111;
   endfunction

   function automatic logic [31:0] zext8(input logic [7:0] b);
      return {24'd0, b};
   endfunction

endpackage

// File: rtl/mem_stage_mc_data_ram.sv
// data_ram: DEPTH x 32 data memory, byte write enables, sync write, async read
module data_ram
   import mem_stage_pkg::*;
#(
   parameter int DEPTH = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // write only the enabled byte lanes; contents survive reset
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_mc.sv
// mem_stage_mc: multi-cycle MEM stage with fault checks, byte access and stall
module mem_stage_mc
   import mem_stage_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 64,
   parameter int BASE_ADDR = 1024,
   parameter int LATENCY   = 0,
   parameter int REG_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_R_EN_in,
   input  logic              MEM_W_EN_in,
   input  logic              WB_Enable_in,
   input  logic              byte_mode,
   input  logic [REG_W-1:0]  Reg_Dest_in,
   input  logic [DATA_W-1:0] Val_RM,
   input  logic [DATA_W-1:0] ALU_result_in,
   output logic              ready,
   output logic              MEM_R_EN_out,
   output logic              WB_Enable_out,
   output logic [REG_W-1:0]  Reg_Dest,
   output logic [DATA_W-1:0] ALU_result,
   output logic [DATA_W-1:0] mem_read_data,
   output logic              addr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = LATENCY > 0 ? $clog2(LATENCY + 1) : 1;
   localparam logic [DATA_W:0] LO = (DATA_W+1)'(BASE_ADDR);
   localparam logic [DATA_W:0] HI = LO + (DATA_W+1)'(4 * DEPTH);
   localparam logic [AW+1:0] BASE_L = (AW+2)'(BASE_ADDR);

   mem_state_t state, state_n;
   logic [CW-1:0] wcnt, wcnt_n;
   logic req, fault, valid, done;
   logic [AW+1:0] off;
   logic [3:0] we;
   logic [DATA_W-1:0] wdata, rword;

   assign req   = MEM_R_EN_in | MEM_W_EN_in;
   assign fault = ({1'b0, ALU_result_in} < LO) || ({1'b0, ALU_result_in} >= HI) ||
                  (!byte_mode && ALU_result_in[1:0] != 2'b00);
   assign addr_err = rst & req & fault;
   assign valid    = rst & req & ~fault;
   // only the low address bits matter for the in-range offset, so subtract narrow
   assign off = ALU_result_in[AW+1:0] - BASE_L;

   // state register; reset aborts any access in flight
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_n;
         wcnt  <= wcnt_n;
      end
   end

   // next state, stall and completion strobe
   always_comb begin
      state_n = state;
      wcnt_n  = wcnt;
      done    = 1'b0;
      ready   = 1'b1;
      if (state == IDLE) begin
         if (valid && LATENCY == 0) done = 1'b1;
         else if (valid) begin
            ready   = 1'b0;
            state_n = BUSY;
            wcnt_n  = CW'(1);
         end
      end else if (!valid) begin
         state_n = IDLE;
         wcnt_n  = '0;
      end else if (wcnt < CW'(LATENCY)) begin
         ready  = 1'b0;
         wcnt_n = wcnt + 1'b1;
      end else begin
         done    = 1'b1;
         state_n = IDLE;
         wcnt_n  = '0;
      end
   end

   assign we    = (done && MEM_W_EN_in) ? byte_we(off[1:0], byte_mode) : 4'b0000;
   assign wdata = byte_mode ? {4{Val_RM[7:0]}} : Val_RM;

   data_ram #(.DEPTH(DEPTH)) u_ram (
      .clk  (clk),
      .we   (we),
      .addr (off[AW+1:2]),
      .wdata(wdata),
      .rdata(rword)
   );

   assign mem_read_data = (done && MEM_R_EN_in) ?
                          (byte_mode ? zext8(rword[{off[1:0], 3'b000} +: 8]) : rword) : '0;
   assign MEM_R_EN_out  = rst & MEM_R_EN_in;
   assign WB_Enable_out = rst & WB_Enable_in & ~addr_err;
   assign Reg_Dest      = Reg_Dest_in;
   assign ALU_result    = ALU_result_in;

endmodule
